binary_to_bcd_seq: RTL and testbench
====================================

Name: binary_to_bcd_seq

Overview:
Sequential, parametrised successor to the combinational 5-bit binary-to-BCD converter. It converts a BIN_WIDTH-bit unsigned binary word into BCD_DIGITS packed BCD digits using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. Input and output use valid/ready handshakes so it can sit between a binary datapath and a display or serial formatter.

Parameters:
BIN_WIDTH, 16, width of binary_input in bits (legal range 1..32)
BCD_DIGITS, 5, number of BCD output digits; must satisfy 10^BCD_DIGITS > 2^BIN_WIDTH - 1 (elaboration-time check, $error if violated)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  binary_input is valid this cycle
in_ready  output  1  block can accept a new word
binary_input  input  BIN_WIDTH  unsigned binary value
out_valid  output  1  bcd_output holds a completed result
out_ready  input  1  downstream accepts the result
bcd_output  output  4*BCD_DIGITS  packed BCD; digit 0 (units) in bits [3:0]
busy  output  1  a conversion is in progress (SHIFT state)

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1, out_valid=0, busy=0, bcd_output=0, internal shift register and bit counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid && in_ready at a rising edge: latch binary_input into the shift register, clear the BCD accumulator, load the bit counter with BIN_WIDTH, go to SHIFT.
- SHIFT: in_ready=0, busy=1. Each cycle, add 3 to every BCD digit >= 5 (all digits in parallel), then shift the {BCD, binary} register left by 1. Decrement the counter. After the BIN_WIDTH-th shift, go to DONE and register the result into bcd_output.
- Latency: out_valid rises exactly BIN_WIDTH cycles after the accepting edge.
- DONE: out_valid=1, busy=0, in_ready=0. bcd_output is held stable while out_valid && !out_ready. On out_valid && out_ready, go to IDLE with out_valid=0. bcd_output keeps its last value after the handoff.
- Throughput: one conversion per BIN_WIDTH+2 cycles at best. There is no overlap of accept and deliver.
- in_valid during SHIFT or DONE is ignored (in_ready=0). binary_input is sampled only at the accepting edge; later changes do not affect the result.
- Digits above the value's magnitude read 0 (no blanking in the base build).
- rst asserted mid-conversion aborts immediately to the reset values. No partial result ever appears with out_valid=1.
- BIN_WIDTH=1 is legal: 1 SHIFT cycle.

Optional Feature:
Macro BCD_SIGNED_INPUT_EN.
- With the macro: binary_input is two's complement. At accept, the block latches the sign and converts the magnitude (-2^(BIN_WIDTH-1) converts correctly as 2^(BIN_WIDTH-1)). An extra output port sign_output (1 bit) is present; it is valid with out_valid, reset value 0, and held under backpressure. The BCD_DIGITS check then uses 2^(BIN_WIDTH-1).
- Without the macro: the input is unsigned, sign_output does not exist, and no negation logic is built.

Test Plan:
- BIN_WIDTH=5, BCD_DIGITS=2, in 5'd31 -> out_valid exactly 5 cycles after accept, bcd_output=8'b0011_0001. Also 5'd0 -> 8'h00 and 5'd21 -> 8'h21.
- Defaults (16/5), in 16'd65535 -> 20'h65535. 16'd0 -> 20'h00000. 16'd1000 -> 20'h01000. Also 16'd9 then 16'd10 -> 20'h00009, 20'h00010 (digit carry boundary).
- Backpressure: out_ready held low 7 cycles after out_valid -> bcd_output stable, in_ready=0 throughout, in_valid pulses ignored. Raising out_ready returns the FSM to IDLE next cycle with in_ready=1.
- Change binary_input every cycle during SHIFT -> result matches only the value sampled at the accepting edge.
- Assert rst at SHIFT cycle 8 of 16 -> out_valid, busy, bcd_output are 0 immediately (asynchronous). After release, a new conversion of 16'd4321 -> 20'h04321.
- BCD_SIGNED_INPUT_EN, 16-bit: in -1 -> sign_output=1, 20'h00001. In -32768 -> sign_output=1, 20'h32768. In 32767 -> sign_output=0, 20'h32767.

Source files
------------

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define BCD_SIGNED_INPUT_EN for two's-complement input with a sign_output port.
module binary_to_bcd_seq #(
    parameter int BIN_WIDTH  = 16,
    parameter int BCD_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_WIDTH-1:0]    binary_input,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*BCD_DIGITS-1:0] bcd_output,
`ifdef BCD_SIGNED_INPUT_EN
    output logic                    sign_output,
`endif
    output logic                    busy
);

    localparam int BW = 4 * BCD_DIGITS;
    localparam int SW = BW + BIN_WIDTH;
    localparam int CW = $clog2(BIN_WIDTH + 1);

    function automatic longint unsigned f_pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

`ifdef BCD_SIGNED_INPUT_EN
    localparam longint unsigned MAXV = 64'd1 << (BIN_WIDTH - 1);
`else
    localparam longint unsigned MAXV = (64'd1 << BIN_WIDTH) - 64'd1;
`endif

    if (BIN_WIDTH < 1 || BIN_WIDTH > 32) begin : g_bad_width
        $error("binary_to_bcd_seq: BIN_WIDTH out of range 1..32");
    end
    if (f_pow10(BCD_DIGITS) <= MAXV) begin : g_bad_digits
        $error("binary_to_bcd_seq: BCD_DIGITS too small for BIN_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [SW-1:0]        r_shift;
    logic [SW-1:0]        w_adj;
    logic [SW-1:0]        w_shifted;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bcd;
    logic [BIN_WIDTH-1:0] w_mag;
    logic                 w_accept;
    logic                 w_last;

`ifdef BCD_SIGNED_INPUT_EN
    logic r_sign;
    logic r_sign_out;

    // Most negative input wraps to 2^(W-1), which is its correct magnitude.
    assign w_mag = binary_input[BIN_WIDTH-1] ? (~binary_input + 1'b1)
                                             : binary_input;
    assign sign_output = r_sign_out;
`else
    assign w_mag = binary_input;
`endif

    assign w_last     = (r_cnt == CW'(1));
    assign bcd_output = r_bcd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        w_accept  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_adj = r_shift;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (r_shift[BIN_WIDTH+4*d +: 4] >= 4'd5)
                w_adj[BIN_WIDTH+4*d +: 4] = r_shift[BIN_WIDTH+4*d +: 4] + 4'd3;
        end
    end

    assign w_shifted = w_adj << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
        end else if (w_accept) begin
            r_shift <= {{BW{1'b0}}, w_mag};
            r_cnt   <= CW'(BIN_WIDTH);
        end else if (r_state == S_SHIFT) begin
            r_shift <= w_shifted;
            r_cnt   <= r_cnt - CW'(1);
            if (w_last) r_bcd <= w_shifted[SW-1 -: BW];
        end
    end

`ifdef BCD_SIGNED_INPUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign     <= 1'b0;
            r_sign_out <= 1'b0;
        end else if (w_accept) begin
            r_sign <= binary_input[BIN_WIDTH-1];
        end else if (r_state == S_SHIFT && w_last) begin
            r_sign_out <= r_sign;
        end
    end
`endif

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Scoreboard bench for binary_to_bcd_seq: 16/5 default instance plus a 5/2 instance.
// Handles BCD_SIGNED_INPUT_EN builds through the reference model.
module tb_binary_to_bcd_seq;

    typedef struct {
        logic [19:0] bcd;
        logic        sgn;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bin;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] bcd;
    logic        busy;
    logic        sgn;

    logic        in_valid5;
    logic        in_ready5;
    logic [4:0]  bin5;
    logic        out_valid5;
    logic [7:0]  bcd5;
    logic        busy5;
    logic        sgn5;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic ov_prev = 1'b0;
    exp_t q[$];
    exp_t q5[$];
    exp_t m_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    binary_to_bcd_seq #(.BIN_WIDTH(16), .BCD_DIGITS(5)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .binary_input(bin),
        .out_valid(out_valid), .out_ready(out_ready), .bcd_output(bcd),
`ifdef BCD_SIGNED_INPUT_EN
        .sign_output(sgn),
`endif
        .busy(busy)
    );

    binary_to_bcd_seq #(.BIN_WIDTH(5), .BCD_DIGITS(2)) u_dut5 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid5), .in_ready(in_ready5), .binary_input(bin5),
        .out_valid(out_valid5), .out_ready(1'b1), .bcd_output(bcd5),
`ifdef BCD_SIGNED_INPUT_EN
        .sign_output(sgn5),
`endif
        .busy(busy5)
    );

`ifndef BCD_SIGNED_INPUT_EN
    assign sgn  = 1'b0;
    assign sgn5 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned f_mag(input logic [31:0] v, input int w,
                                          output logic s);
`ifdef BCD_SIGNED_INPUT_EN
        s = v[w-1];
        if (s) return (32'd1 << w) - v;
        return v;
`else
        s = 1'b0;
        return v;
`endif
    endfunction

    function automatic logic [19:0] f_bcd(input int unsigned v);
        logic [19:0]  r;
        int unsigned  t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic send(input logic [15:0] v);
        int   n;
        logic s;
        exp_t e;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) begin
            chk("send_timeout", 32'd1, 32'd0);
            return;
        end
        bin = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.bcd = f_bcd(f_mag(32'(v), 16, s));
        e.sgn = s;
        e.acc = cyc;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || !in_ready) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic conv5(input logic [4:0] v);
        int   n;
        logic s;
        exp_t e;
        n = 0;
        while (!in_ready5 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        bin5 = v;
        in_valid5 = 1'b1;
        @(posedge clk); #1;
        in_valid5 = 1'b0;
        e.bcd = f_bcd(f_mag(32'(v), 5, s));
        e.sgn = s;
        e.acc = 0;
        q5.push_back(e);
        n = 0;
        while (!out_valid5 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("lat5", 32'(n), 32'd5);
        e = q5.pop_front();
        chk("bcd5", 32'(bcd5), 32'(e.bcd[7:0]));
        chk("sign5", 32'(sgn5), 32'(e.sgn));
        @(posedge clk); #1;
        chk("idle5", 32'(in_ready5), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev && q.size() > 0)
                chk("latency", 32'(cyc - q[0].acc), 32'd16);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    m_e = q.pop_front();
                    chk("bcd", 32'(bcd), 32'(m_e.bcd));
                    chk("sign", 32'(sgn), 32'(m_e.sgn));
                end
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        logic s;
        logic [19:0] bp_exp;
        rst = 1'b1;
        in_valid = 1'b0;
        bin = '0;
        out_ready = 1'b1;
        in_valid5 = 1'b0;
        bin5 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_out_valid5", 32'(out_valid5), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        conv5(5'd31);
        conv5(5'd0);
        conv5(5'd21);

        send(16'd65535);
        send(16'd0);
        send(16'd1000);
        send(16'd9);
        send(16'd10);
        send(16'd12345);
        send(16'd1);
`ifdef BCD_SIGNED_INPUT_EN
        send(16'hFFFF);
        send(16'h8000);
        send(16'h7FFF);
`endif
        wait_idle();

        // backpressure
        out_ready = 1'b0;
        send(16'd4095);
        bp_exp = f_bcd(f_mag(32'd4095, 16, s));
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 7; i++) begin
            in_valid = i[0];
            bin = 16'($urandom);
            @(posedge clk); #1;
            chk("bp_bcd", 32'(bcd), 32'(bp_exp));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("bp_no_extra", 32'(q.size()), 32'd0);
        chk("bp_idle", 32'(busy), 32'd0);

        // input changes during SHIFT must not matter
        send(16'd2468);
        for (int i = 0; i < 16; i++) begin
            bin = 16'($urandom);
            @(posedge clk); #1;
        end
        wait_idle();

        // async abort mid-conversion
        send(16'd12345);
        repeat (7) @(posedge clk);
        #1;
        chk("abort_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bcd", 32'(bcd), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(16'd4321);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
